// File: rtl/game_status_rx.sv
// Host-side receiver for the cannon game's status pins: synchronizes the pins,
// detects shot results and keeps per-game tallies under an IDLE/PLAY/OVER FSM.
module game_status_rx #(
    parameter int SHOTS_PER_GAME = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       result_valid_pin,
    input  logic       hit_pin,
    input  logic [4:0] target_x_pin,
    input  logic       target_top_pin,
    input  logic       start_new_game,
    output logic [4:0] shots,
    output logic [4:0] hits,
    output logic [4:0] streak,
    output logic [4:0] best_streak,
    output logic [4:0] last_target_x,
    output logic       last_target_top,
    output logic       shot_pulse,
    output logic       hit_pulse,
    output logic       playing,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_OVER
    } state_t;

    localparam logic [4:0] LP_LAST_SHOT = 5'(SHOTS_PER_GAME);

    logic       r_valid_s1, r_valid_s2, r_valid_prev;
    logic       r_hit_s1, r_hit_s2;
    logic [4:0] r_tx_s1, r_tx_s2;
    logic       r_top_s1, r_top_s2;
    logic       r_start_prev;

    state_t     r_state;
    logic [4:0] r_shots, r_hits, r_streak, r_best, r_last_tx;
    logic       r_last_top, r_shot_pulse, r_hit_pulse, r_playing, r_game_over;

    logic       w_result_edge, w_start_edge;
    logic [4:0] w_shots_next, w_streak_next;

    // Stage 0/1: two-flop synchronizers plus edge-history flops, never gated.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_s1   <= 1'b0;
            r_valid_s2   <= 1'b0;
            r_valid_prev <= 1'b0;
            r_hit_s1     <= 1'b0;
            r_hit_s2     <= 1'b0;
            r_tx_s1      <= 5'd0;
            r_tx_s2      <= 5'd0;
            r_top_s1     <= 1'b0;
            r_top_s2     <= 1'b0;
            r_start_prev <= 1'b0;
        end else begin
            r_valid_s1   <= result_valid_pin;
            r_valid_s2   <= r_valid_s1;
            r_valid_prev <= r_valid_s2;
            r_hit_s1     <= hit_pin;
            r_hit_s2     <= r_hit_s1;
            r_tx_s1      <= target_x_pin;
            r_tx_s2      <= r_tx_s1;
            r_top_s1     <= target_top_pin;
            r_top_s2     <= r_top_s1;
            r_start_prev <= start_new_game;
        end
    end

    assign w_result_edge = r_valid_s2 & ~r_valid_prev;
    assign w_start_edge  = start_new_game & ~r_start_prev;
    assign w_shots_next  = r_shots + 5'd1;
    assign w_streak_next = r_streak + 5'd1;

    // Stage 2: game FSM and tallies; a start edge outranks a coincident result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_shots      <= 5'd0;
            r_hits       <= 5'd0;
            r_streak     <= 5'd0;
            r_best       <= 5'd0;
            r_last_tx    <= 5'd0;
            r_last_top   <= 1'b0;
            r_shot_pulse <= 1'b0;
            r_hit_pulse  <= 1'b0;
            r_playing    <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_shot_pulse <= 1'b0;
            r_hit_pulse  <= 1'b0;
            if (ena) begin
                if (w_start_edge) begin
                    r_state     <= ST_PLAY;
                    r_playing   <= 1'b1;
                    r_game_over <= 1'b0;
                    r_shots     <= 5'd0;
                    r_hits      <= 5'd0;
                    r_streak    <= 5'd0;
                    r_best      <= 5'd0;
                    r_last_tx   <= 5'd0;
                    r_last_top  <= 1'b0;
                end else if (r_state == ST_PLAY && w_result_edge) begin
                    r_shots      <= w_shots_next;
                    r_last_tx    <= r_tx_s2;
                    r_last_top   <= r_top_s2;
                    r_shot_pulse <= 1'b1;
                    if (r_hit_s2) begin
                        r_hits      <= r_hits + 5'd1;
                        r_streak    <= w_streak_next;
                        r_hit_pulse <= 1'b1;
                        if (w_streak_next > r_best) begin
                            r_best <= w_streak_next;
                        end
                    end else begin
                        r_streak <= 5'd0;
                    end
                    if (w_shots_next == LP_LAST_SHOT) begin
                        r_state     <= ST_OVER;
                        r_playing   <= 1'b0;
                        r_game_over <= 1'b1;
                    end
                end
            end
        end
    end

    assign shots           = r_shots;
    assign hits            = r_hits;
    assign streak          = r_streak;
    assign best_streak     = r_best;
    assign last_target_x   = r_last_tx;
    assign last_target_top = r_last_top;
    assign shot_pulse      = r_shot_pulse;
    assign hit_pulse       = r_hit_pulse;
    assign playing         = r_playing;
    assign game_over       = r_game_over;

endmodule

// File: tb/tb_game_status_rx.sv
// Scoreboard bench for game_status_rx with a four-shot game.
module tb_game_status_rx;

    localparam int SHOTS = 4;

    typedef struct {
        logic [4:0] shots;
        logic [4:0] hits;
        logic [4:0] streak;
        logic [4:0] best;
        logic [4:0] tx;
        logic       top;
        logic       hit;
        logic       over;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b1;
    logic       result_valid_pin = 1'b0;
    logic       hit_pin = 1'b0;
    logic [4:0] target_x_pin = 5'd0;
    logic       target_top_pin = 1'b0;
    logic       start_new_game = 1'b0;
    logic [4:0] shots, hits, streak, best_streak, last_target_x;
    logic       last_target_top, shot_pulse, hit_pulse, playing, game_over;

    int n_vec = 0;
    int n_miss = 0;
    exp_t q[$];
    int m_shots, m_hits, m_streak, m_best;

    game_status_rx #(.SHOTS_PER_GAME(SHOTS)) dut (
        .clk(clk), .reset(reset), .ena(ena),
        .result_valid_pin(result_valid_pin), .hit_pin(hit_pin),
        .target_x_pin(target_x_pin), .target_top_pin(target_top_pin),
        .start_new_game(start_new_game),
        .shots(shots), .hits(hits), .streak(streak), .best_streak(best_streak),
        .last_target_x(last_target_x), .last_target_top(last_target_top),
        .shot_pulse(shot_pulse), .hit_pulse(hit_pulse),
        .playing(playing), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_shots = 0; m_hits = 0; m_streak = 0; m_best = 0;
    endtask

    task automatic model_push(input logic h, input logic [4:0] tx, input logic top);
        exp_t e;
        m_shots++;
        if (h) begin
            m_hits++;
            m_streak++;
            if (m_streak > m_best) m_best = m_streak;
        end else begin
            m_streak = 0;
        end
        e.shots = 5'(m_shots); e.hits = 5'(m_hits); e.streak = 5'(m_streak);
        e.best = 5'(m_best); e.tx = tx; e.top = top; e.hit = h;
        e.over = (m_shots == SHOTS);
        q.push_back(e);
    endtask

    // Result pulse: valid high 3 cycles, low 3 cycles, data held throughout.
    task automatic send(input logic h, input logic [4:0] tx, input logic top, input bit acc);
        @(negedge clk);
        hit_pin = h; target_x_pin = tx; target_top_pin = top; result_valid_pin = 1'b1;
        if (acc) model_push(h, tx, top);
        repeat (3) @(negedge clk);
        result_valid_pin = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic start_game();
        @(negedge clk);
        start_new_game = 1'b1;
        model_clear();
        @(posedge clk); #1;
        chk("start_playing", playing, 1);
        chk("start_shots", shots, 0);
        @(negedge clk);
        start_new_game = 1'b0;
    endtask

    always @(negedge clk) begin
        if (shot_pulse) begin
            if (q.size() == 0) begin
                chk("unexpected_shot_pulse", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_shots", shots, e.shots);
                chk("sb_hits", hits, e.hits);
                chk("sb_streak", streak, e.streak);
                chk("sb_best", best_streak, e.best);
                chk("sb_last_tx", last_target_x, e.tx);
                chk("sb_last_top", last_target_top, e.top);
                chk("sb_hit_pulse", hit_pulse, e.hit);
                chk("sb_game_over", game_over, e.over);
            end
        end else if (hit_pulse) begin
            chk("hit_pulse_without_shot", 1, 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        // Reset, then results with no start are ignored.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_shots", shots, 0);
        chk("rst_playing", playing, 0);
        chk("rst_over", game_over, 0);
        chk("rst_pulse", shot_pulse, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b1, 5'(i + 3), 1'b0, 1'b0);
        chk("idle_shots", shots, 0);
        chk("idle_playing", playing, 0);

        // Full game H,H,M,H then an extra result.
        start_game();
        send(1'b1, 5'd1, 1'b0, 1'b1);
        send(1'b1, 5'd2, 1'b1, 1'b1);
        send(1'b0, 5'd3, 1'b0, 1'b1);
        send(1'b1, 5'd4, 1'b1, 1'b1);
        chk("game_shots", shots, 4);
        chk("game_hits", hits, 3);
        chk("game_streak", streak, 1);
        chk("game_best", best_streak, 2);
        chk("game_over", game_over, 1);
        chk("game_playing", playing, 0);
        send(1'b1, 5'd9, 1'b0, 1'b0);
        chk("over_hold_shots", shots, 4);

        // Restart mid-game after two hits.
        start_game();
        send(1'b1, 5'd7, 1'b1, 1'b1);
        send(1'b1, 5'd8, 1'b0, 1'b1);
        chk("pre_restart_hits", hits, 2);
        start_game();
        chk("restart_hits", hits, 0);
        chk("restart_streak", streak, 0);
        chk("restart_best", best_streak, 0);
        chk("restart_tx", last_target_x, 0);
        chk("restart_over", game_over, 0);

        // Start edge coincident with a result edge: start wins, result dropped.
        send(1'b1, 5'd5, 1'b0, 1'b1);
        @(negedge clk);
        hit_pin = 1'b1; target_x_pin = 5'd11; result_valid_pin = 1'b1;
        repeat (2) @(negedge clk);
        start_new_game = 1'b1;
        model_clear();
        @(posedge clk); #1;
        chk("simul_pulse", shot_pulse, 0);
        chk("simul_shots", shots, 0);
        chk("simul_playing", playing, 1);
        @(negedge clk);
        start_new_game = 1'b0;
        result_valid_pin = 1'b0;
        repeat (3) @(negedge clk);

        // Capture and latency: pin rise before edge k, pulse after edge k+2.
        @(negedge clk);
        hit_pin = 1'b1; target_x_pin = 5'd19; target_top_pin = 1'b1; result_valid_pin = 1'b1;
        model_push(1'b1, 5'd19, 1'b1);
        @(posedge clk); #1;
        chk("lat_k", shot_pulse, 0);
        @(posedge clk); #1;
        chk("lat_k1", shot_pulse, 0);
        @(posedge clk); #1;
        chk("lat_k2_shot", shot_pulse, 1);
        chk("lat_k2_hit", hit_pulse, 1);
        chk("lat_tx", last_target_x, 19);
        chk("lat_top", last_target_top, 1);
        @(posedge clk); #1;
        chk("lat_k3_one_cycle", shot_pulse, 0);
        @(negedge clk);
        result_valid_pin = 1'b0;
        repeat (3) @(negedge clk);

        // ena gating: a result while disabled is lost.
        ena = 1'b0;
        send(1'b0, 5'd2, 1'b0, 1'b0);
        ena = 1'b1;
        chk("ena_off_shots", shots, 1);
        send(1'b0, 5'd3, 1'b0, 1'b1);
        chk("ena_on_shots", shots, 2);

        // Reset mid-game with shots=3.
        send(1'b1, 5'd6, 1'b0, 1'b1);
        chk("premid_shots", shots, 3);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_shots", shots, 0);
        chk("midrst_hits", hits, 0);
        chk("midrst_streak", streak, 0);
        chk("midrst_best", best_streak, 0);
        chk("midrst_tx", last_target_x, 0);
        chk("midrst_playing", playing, 0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        send(1'b1, 5'd12, 1'b0, 1'b0);
        chk("postrst_ignored", shots, 0);
        start_game();
        send(1'b1, 5'd13, 1'b1, 1'b1);
        chk("postrst_shots", shots, 1);

        chk("sb_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/game_status_rx.md
# game_status_rx

Host-side receiver for the cannon game's status pins. It synchronizes the game's result_valid/hit pin pair and target_x/target-top pins, and detects each new shot result. It keeps per-game tallies (shots, hits, current streak, best streak) and runs an IDLE/PLAY/OVER game state machine. It sits on the board-controller side, consuming what the game core drives on its dedicated and bidirectional outputs.

## Interface
Parameters:
- SHOTS_PER_GAME, 16: shots per game; legal range 1..31.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ena  in  1  event-processing enable.
- result_valid_pin  in  1  game's result_valid pin (asynchronous to clk).
- hit_pin  in  1  game's hit pin (asynchronous).
- target_x_pin  in  5  game's target_x pins (asynchronous).
- target_top_pin  in  1  game's target_y==31 flag pin (asynchronous).
- start_new_game  in  1  host request to start a game (level, synchronous to clk).
- shots  out  5  results counted this game.
- hits  out  5  hits counted this game.
- streak  out  5  current consecutive-hit count.
- best_streak  out  5  longest streak this game.
- last_target_x  out  5  target_x captured with the latest result.
- last_target_top  out  1  target_top captured with the latest result.
- shot_pulse  out  1  one-cycle strobe per accepted result.
- hit_pulse  out  1  one-cycle strobe per accepted hit.
- playing  out  1  FSM in PLAY.
- game_over  out  1  FSM in OVER.

## Operation
- Every pin input passes through a 2-flop synchronizer. The synchronizers run regardless of ena and state.
- A third flop on synced valid provides edge detection. A result edge is synced_valid=1 and prev_valid=0.
- Hit, target_x and target_top are sampled from their synchronizer outputs in the same cycle as the result edge.
- Sender contract:
  - hit, target_x and target_top are stable from result_valid rise until its fall.
  - result_valid high ≥2 clk and low ≥2 clk between results.
- start edge: start_new_game=1 and its previous-cycle value 0.
- FSM:
  - IDLE (reset state): results ignored; start edge -> PLAY.
  - PLAY, start edge -> PLAY:
    - Clears shots, hits, streak, best_streak, last_target_x, last_target_top.
  - PLAY, result edge:
    - shots+=1; last_target_x and last_target_top captured; shot_pulse=1.
    - On a hit: hits+=1, streak+=1, best_streak=max(best_streak, streak+1), hit_pulse=1.
    - On a miss: streak=0.
    - If shots+1 == SHOTS_PER_GAME -> OVER.
  - OVER: results ignored and counters hold; start edge -> PLAY with a clear.
- The start edge in IDLE also clears all counters.
- Simultaneous start edge and result edge: start wins. Counters clear and that result is dropped; no pulse.
- ena=0: FSM, counters and pulses are frozen; shot_pulse/hit_pulse=0. Edges occurring while ena=0 are lost, not queued.
- Width: counters cannot exceed SHOTS_PER_GAME ≤31, so no wrap or saturation logic is needed. hits ≤ shots and best_streak ≤ hits always hold.

## Timing
- Reset values:
  - All counters and last_target_* = 0.
  - shot_pulse, hit_pulse, playing, game_over = 0.
  - State = IDLE; synchronizer and edge flops = 0.
- Result latency: result_valid_pin rises before edge E0 -> counters and pulses update at E2 (visible 3 clocks after the pin change at worst).
- Pulses are registered and high exactly one cycle, coincident with the counter update.
- Start latency: start_new_game rises before edge E0 -> clear/state change visible after E0.
- playing/game_over are registered decodes of state. game_over asserts in the same cycle as the final shot_pulse.
- Reset mid-game has priority over everything: all outputs return to reset values at the next edge.

## Test plan
- Reset then idle results: assert reset 2 cycles, then send 3 results without start -> shots=0, no shot_pulse, playing=0.
- Full game, SHOTS_PER_GAME=4: start, then results H,H,M,H -> shots=4, hits=3, streak=1, best_streak=2, game_over=1 with the 4th shot_pulse. A 5th result leaves shots=4.
- Capture and latency: hold target_x_pin=5'd19, target_top_pin=1, send a hit with pin rise before edge k -> shot_pulse/hit_pulse high in cycle k+2; last_target_x=19, last_target_top=1.
- Restart: start edge mid-game after 2 hits -> all counters 0 next cycle, playing=1. A start edge in the same cycle as a result edge -> counters 0, no pulse.
- ena gating: in PLAY, ena=0 across one result pulse -> shots unchanged. ena=1 and next result -> shots+=1.
- Reset mid-game: in PLAY with shots=3, assert reset 1 cycle -> all outputs 0, IDLE; a following result is ignored until a start edge.
